// File: rtl/mau_pkg.sv
// Shared constants for the MEM-stage load/store unit:
// access sizes, fault cause codes and data BRAM depth.
package mau_pkg;

  localparam int DM_WORDS = 3072;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] CAUSE_OK       = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_RANGE    = 2'd2;
  localparam logic [1:0] CAUSE_SIZE     = 2'd3;

endpackage

// File: rtl/mau_load_align.sv
// Combinational load alignment: picks the byte/half lane out of
// rdata and sign- or zero-extends it. Ports: rdata, size, uns, lane -> data.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (lane)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (size)
      SZ_BYTE: data = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: data = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for the data BRAM. Ports: req_* from EX/MEM,
// rsp_* to WB (valid/ready), mem_* to the synchronous-read BRAM.
module mem_access_unit #(
  parameter int DM_WORDS = mau_pkg::DM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_is_load,
  output logic [1:0]  rsp_cause,
  output logic [11:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  import mau_pkg::*;

  logic        acc;
  logic [1:0]  cause;
  logic [3:0]  be;

  logic        r_valid;
  logic        r_hold;
  logic        r_load;
  logic [4:0]  r_rd;
  logic [1:0]  r_cause;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_lane;
  logic [31:0] r_hdata;
  logic [31:0] ext;

  assign req_ready = !rst && (!r_valid || rsp_ready);
  assign acc       = req_valid && req_ready;

  always_comb begin
    cause = CAUSE_OK;
    if (req_size == SZ_ILL)
      cause = CAUSE_SIZE;
    else if ((req_size == SZ_HALF && req_addr[0]) ||
             (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
      cause = CAUSE_MISALIGN;
    else if ({2'b00, req_addr[31:2]} >= 32'(DM_WORDS))
      cause = CAUSE_RANGE;
  end

  always_comb begin
    be = 4'b0000;
    case (req_size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: be = req_addr[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << req_addr[1:0];
      default: be = 4'b0000;
    endcase
  end

  assign mem_addr  = acc ? req_addr[13:2] : 12'd0;
  assign mem_be    = acc ? be : 4'b0000;
  assign mem_write = acc && req_we && (cause == CAUSE_OK);
  assign mem_wdata = req_wdata;

  mau_load_align u_align (
    .rdata (mem_rdata),
    .size  (r_size),
    .uns   (r_uns),
    .lane  (r_lane),
    .data  (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
      r_load  <= 1'b0;
      r_rd    <= 5'd0;
      r_cause <= CAUSE_OK;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_lane  <= 2'd0;
      r_hdata <= 32'd0;
    end else if (acc) begin
      r_valid <= 1'b1;
      r_hold  <= 1'b0;
      r_load  <= !req_we;
      r_rd    <= req_rd;
      r_cause <= cause;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_lane  <= req_addr[1:0];
    end else if (r_valid && rsp_ready) begin
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
    end else if (r_valid && !r_hold) begin
      // mem_rdata is only valid this one cycle; keep a copy for the stall
      r_hold  <= 1'b1;
      r_hdata <= ext;
    end
  end

  assign rsp_valid   = r_valid;
  assign rsp_rd      = r_rd;
  assign rsp_is_load = r_load;
  assign rsp_cause   = r_cause;
  assign rsp_data    = (r_valid && r_load && r_cause == CAUSE_OK)
                     ? (r_hold ? r_hdata : ext) : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural
// byte-enabled synchronous-read BRAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_is_load;
  logic [1:0]  rsp_cause;
  logic [11:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] dmem [0:3071];
  logic [31:0] noise;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_rd       (rsp_rd),
    .rsp_is_load  (rsp_is_load),
    .rsp_cause    (rsp_cause),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // BRAM: sub-word store data comes from the low bits of wdata
  always @(posedge clk) begin
    if (mem_write && mem_addr < 12'd3072) begin
      case (mem_be)
        4'b1111: dmem[mem_addr] <= mem_wdata;
        4'b0011: dmem[mem_addr][15:0] <= mem_wdata[15:0];
        4'b1100: dmem[mem_addr][31:16] <= mem_wdata[15:0];
        4'b0001: dmem[mem_addr][7:0] <= mem_wdata[7:0];
        4'b0010: dmem[mem_addr][15:8] <= mem_wdata[7:0];
        4'b0100: dmem[mem_addr][23:16] <= mem_wdata[7:0];
        4'b1000: dmem[mem_addr][31:24] <= mem_wdata[7:0];
        default: ;
      endcase
    end
    if (mem_addr < 12'd3072)
      mem_rdata <= dmem[mem_addr] ^ noise;
    else
      mem_rdata <= noise;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) dmem[i] = 32'd0;
    noise = 32'd0;
    mem_rdata = 32'd0;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_rd = 5'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_rd", 32'(rsp_rd), 32'd0);
    chk("rst_cause", 32'(rsp_cause), 32'd0);
    chk("rst_isload", 32'(rsp_is_load), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    // word store then word load
    @(negedge clk);
    req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1);
    #1;
    chk("sw_write", 32'(mem_write), 32'd1);
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_addr", 32'(mem_addr), 32'h040);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("sw_rsp_isload", 32'(rsp_is_load), 32'd0);
    chk("sw_rsp_data", rsp_data, 32'd0);
    req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5);
    #1;
    chk("lw_write", 32'(mem_write), 32'd0);
    chk("lw_addr", 32'(mem_addr), 32'h040);
    @(negedge clk);
    chk("lw_valid", 32'(rsp_valid), 32'd1);
    chk("lw_data", rsp_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(rsp_rd), 32'd5);
    chk("lw_isload", 32'(rsp_is_load), 32'd1);

    // byte store, signed and unsigned byte loads
    req(1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080, 5'd2);
    #1;
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", 32'(mem_wdata[7:0]), 32'h80);
    chk("sb_write", 32'(mem_write), 32'd1);
    @(negedge clk);
    req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd6);
    @(negedge clk);
    chk("lb_data", rsp_data, 32'hFFFFFF80);
    req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7);
    @(negedge clk);
    chk("lbu_data", rsp_data, 32'h00000080);
    chk("lbu_rd", 32'(rsp_rd), 32'd7);

    // half store, misaligned half load and word store
    req(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 5'd3);
    #1;
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_write", 32'(mem_write), 32'd1);
    @(negedge clk);
    req(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 5'd8);
    #1;
    chk("lh_mis_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("lh_mis_cause", 32'(rsp_cause), 32'd1);
    chk("lh_mis_data", rsp_data, 32'd0);
    req(1'b1, 2'b10, 1'b0, 32'h302, 32'h11111111, 5'd9);
    #1;
    chk("sw_mis_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("sw_mis_cause", 32'(rsp_cause), 32'd1);
    req(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd10);
    @(negedge clk);
    chk("lh_data", rsp_data, 32'h00001234);

    // range and illegal size
    req(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 5'd11);
    #1;
    chk("rng_ld_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("rng_ld_cause", 32'(rsp_cause), 32'd2);
    chk("rng_ld_data", rsp_data, 32'd0);
    req(1'b1, 2'b10, 1'b0, 32'h3000, 32'h22222222, 5'd12);
    #1;
    chk("rng_st_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("rng_st_cause", 32'(rsp_cause), 32'd2);
    req(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 5'd13);
    @(negedge clk);
    chk("ill_cause", 32'(rsp_cause), 32'd3);

    // stall: response held while mem_rdata wanders
    req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd14);
    @(negedge clk);
    chk("stl_data0", rsp_data, 32'h80ADBEEF);
    rsp_ready = 1'b0;
    req(1'b1, 2'b10, 1'b0, 32'h104, 32'h00000055, 5'd15);
    #1;
    chk("stl_ready", 32'(req_ready), 32'd0);
    chk("stl_write", 32'(mem_write), 32'd0);
    chk("stl_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      noise = 32'h1111_1111 * (i + 1);
      @(negedge clk);
      chk("stl_hold_data", rsp_data, 32'h80ADBEEF);
      chk("stl_hold_rd", 32'(rsp_rd), 32'd14);
      chk("stl_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    chk("rel_write", 32'(mem_write), 32'd1);
    chk("rel_addr", 32'(mem_addr), 32'h041);
    @(negedge clk);
    noise = 32'd0;
    chk("rel_valid", 32'(rsp_valid), 32'd1);
    chk("rel_rd", 32'(rsp_rd), 32'd15);
    chk("rel_isload", 32'(rsp_is_load), 32'd0);
    chk("rel_mem", dmem[12'h041], 32'h00000055);

    // reset with a pending response and a store on the bus
    req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd16);
    @(negedge clk);
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_data", rsp_data, 32'h12340000);
    rst = 1'b1;
    req(1'b1, 2'b10, 1'b0, 32'h200, 32'hCAFEF00D, 5'd17);
    #1;
    chk("rstq_write", 32'(mem_write), 32'd0);
    chk("rstq_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rstq_valid", 32'(rsp_valid), 32'd0);
    chk("rstq_write2", 32'(mem_write), 32'd0);
    chk("rstq_mem", dmem[12'h080], 32'h12340000);
    rst = 1'b0;
    req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5'd18);
    @(negedge clk);
    req_valid = 1'b0;
    chk("post_rst_data", rsp_data, 32'h12340000);
    @(negedge clk);
    chk("idle_valid", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
